// File: rtl/key_mode_sel.sv
// Per-channel mode selector: PPS qualifying pulses in one direction step a
// bounded mode value up or down, with optional inter-pulse timeout and wrap/saturate ends.
module key_mode_sel #(
  parameter int CH          = 2,
  parameter int MODES       = 3,
  parameter int PPS         = 2,
  parameter int TIMEOUT_CYC = 0,
  parameter int WRAP        = 1,
  localparam int MW         = ($clog2(MODES) < 1) ? 1 : $clog2(MODES)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH-1:0]     inc_pulse,
  input  logic [CH-1:0]     dec_pulse,
  input  logic [CH-1:0]     clr,
  output logic [CH*MW-1:0]  mode,
  output logic [CH-1:0]     step
);

  localparam int TW = 20;
  localparam logic [MW-1:0] MODE_MAX = MW'(MODES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC);
  localparam logic [2:0]    PPS_V    = 3'(PPS);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [2:0]    pend_q, pend_d, cnt;
    logic          dir_q, dir_d, pdir;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [MW-1:0] mode_q, mode_d, nxt_mode;
    logic          step_q, step_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        pend_q <= '0;
        dir_q  <= 1'b0;
        tmr_q  <= '0;
        mode_q <= '0;
        step_q <= 1'b0;
      end else begin
        pend_q <= pend_d;
        dir_q  <= dir_d;
        tmr_q  <= tmr_d;
        mode_q <= mode_d;
        step_q <= step_d;
      end
    end

    // dir = 1 means DEC; an opposing pulse restarts the count at 1
    always_comb begin
      pdir = dec_pulse[g];
      cnt  = (pend_q == 3'd0 || dir_q == pdir) ? pend_q + 3'd1 : 3'd1;
      if (!pdir)
        nxt_mode = (mode_q == MODE_MAX) ? ((WRAP != 0) ? '0 : mode_q) : mode_q + 1'b1;
      else
        nxt_mode = (mode_q == '0) ? ((WRAP != 0) ? MODE_MAX : mode_q) : mode_q - 1'b1;
    end

    always_comb begin
      pend_d = pend_q;
      dir_d  = dir_q;
      tmr_d  = tmr_q;
      mode_d = mode_q;
      step_d = 1'b0;
      if (clr[g]) begin
        pend_d = '0;
        dir_d  = 1'b0;
        tmr_d  = '0;
        mode_d = '0;
      end else if (inc_pulse[g] && dec_pulse[g]) begin
        pend_d = pend_q;
      end else if (inc_pulse[g] || dec_pulse[g]) begin
        dir_d = pdir;
        if (cnt == PPS_V) begin
          pend_d = '0;
          tmr_d  = '0;
          mode_d = nxt_mode;
          step_d = (nxt_mode != mode_q);
        end else begin
          pend_d = cnt;
          tmr_d  = TO_LOAD;
        end
      end else if (TIMEOUT_CYC > 0 && pend_q != 3'd0) begin
        if (tmr_q <= TW'(1)) begin
          pend_d = '0;
          tmr_d  = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
    end

    assign mode[g*MW +: MW] = mode_q;
    assign step[g]          = step_q;
  end

endmodule

// File: tb/tb_key_mode_sel.sv
// Bench for key_mode_sel: five parameterisations share one stimulus stream and
// are compared every cycle against an integer model of the pulse/mode rules.
module tb_key_mode_sel;
  localparam int K = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] inc_pulse = '0, dec_pulse = '0, clr = '0;
  logic [3:0] mode_a, mode_b, mode_c, mode_e;
  logic [5:0] mode_d;
  logic [1:0] step_a, step_b, step_c, step_d, step_e;

  int p_modes[K] = '{3, 3, 3, 5, 4};
  int p_pps[K]   = '{2, 2, 2, 1, 3};
  int p_to[K]    = '{0, 0, 8, 0, 5};
  int p_wrap[K]  = '{1, 0, 1, 1, 0};

  int m_mode[K][2], m_pend[K][2], m_dir[K][2], m_idle[K][2], m_step[K][2];
  int n_checks = 0, n_errors = 0;
  int st_a0 = 0, st_b0 = 0;

  always #5 sys_clk = ~sys_clk;

  key_mode_sel #(.CH(2), .MODES(3), .PPS(2), .TIMEOUT_CYC(0), .WRAP(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .mode(mode_a), .step(step_a));
  key_mode_sel #(.CH(2), .MODES(3), .PPS(2), .TIMEOUT_CYC(0), .WRAP(0)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .mode(mode_b), .step(step_b));
  key_mode_sel #(.CH(2), .MODES(3), .PPS(2), .TIMEOUT_CYC(8), .WRAP(1)) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .mode(mode_c), .step(step_c));
  key_mode_sel #(.CH(2), .MODES(5), .PPS(1), .TIMEOUT_CYC(0), .WRAP(1)) dut_d (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .mode(mode_d), .step(step_d));
  key_mode_sel #(.CH(2), .MODES(4), .PPS(3), .TIMEOUT_CYC(5), .WRAP(0)) dut_e (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .clr(clr), .mode(mode_e), .step(step_e));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_mode(int k, int c);
    case (k)
      0: return 32'(mode_a[c*2 +: 2]);
      1: return 32'(mode_b[c*2 +: 2]);
      2: return 32'(mode_c[c*2 +: 2]);
      3: return 32'(mode_d[c*3 +: 3]);
      default: return 32'(mode_e[c*2 +: 2]);
    endcase
  endfunction

  function automatic logic [31:0] get_step(int k, int c);
    case (k)
      0: return 32'(step_a[c]);
      1: return 32'(step_b[c]);
      2: return 32'(step_c[c]);
      3: return 32'(step_d[c]);
      default: return 32'(step_e[c]);
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < K; k++)
      for (int c = 0; c < 2; c++) begin
        m_mode[k][c] = 0; m_pend[k][c] = 0; m_dir[k][c] = 0;
        m_idle[k][c] = 0; m_step[k][c] = 0;
      end
  endfunction

  // One clock edge of the reference behaviour, written as integer rules
  function automatic void model_cycle(logic [1:0] inc, logic [1:0] dec, logic [1:0] cl);
    int nd, cnt, nm;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < 2; c++) begin
        m_step[k][c] = 0;
        if (cl[c]) begin
          m_mode[k][c] = 0; m_pend[k][c] = 0; m_idle[k][c] = 0;
        end else if (inc[c] && dec[c]) begin
          nd = 0;
        end else if (inc[c] || dec[c]) begin
          nd  = dec[c] ? 1 : 0;
          cnt = (m_pend[k][c] == 0 || m_dir[k][c] == nd) ? m_pend[k][c] + 1 : 1;
          m_dir[k][c]  = nd;
          m_idle[k][c] = 0;
          if (cnt == p_pps[k]) begin
            m_pend[k][c] = 0;
            if (nd == 0) nm = (m_mode[k][c] + 1 < p_modes[k]) ? m_mode[k][c] + 1 : (p_wrap[k] != 0 ? 0 : m_mode[k][c]);
            else         nm = (m_mode[k][c] > 0) ? m_mode[k][c] - 1 : (p_wrap[k] != 0 ? p_modes[k] - 1 : 0);
            m_step[k][c] = (nm != m_mode[k][c]) ? 1 : 0;
            m_mode[k][c] = nm;
          end else begin
            m_pend[k][c] = cnt;
          end
        end else if (p_to[k] > 0 && m_pend[k][c] > 0) begin
          m_idle[k][c]++;
          if (m_idle[k][c] >= p_to[k]) begin
            m_pend[k][c] = 0; m_idle[k][c] = 0;
          end
        end
      end
  endfunction

  task automatic compare_all(input string where);
    for (int k = 0; k < K; k++)
      for (int c = 0; c < 2; c++) begin
        check($sformatf("%s k%0d c%0d mode", where, k, c), get_mode(k, c), 32'(m_mode[k][c]));
        check($sformatf("%s k%0d c%0d step", where, k, c), get_step(k, c), 32'(m_step[k][c]));
      end
  endtask

  task automatic tick(input logic [1:0] i, input logic [1:0] d, input logic [1:0] cl);
    @(negedge sys_clk);
    inc_pulse = i; dec_pulse = d; clr = cl;
    @(posedge sys_clk);
    model_cycle(i, d, cl);
    #1;
    compare_all("cyc");
    if (step_a[0]) st_a0++;
    if (step_b[0]) st_b0++;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    inc_pulse = '0; dec_pulse = '0; clr = '0;
    #2 sys_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] ri, rd, rc;
    model_reset();
    #1 compare_all("por");
    do_reset();

    // Defaults: six incs on ch0 give 1,2,0 with three strobes
    st_a0 = 0;
    repeat (6) tick(2'b01, 2'b00, 2'b00);
    check("wrap_steps", 32'(st_a0), 32'd3);
    check("wrap_mode0", get_mode(0, 0), 32'd0);
    check("wrap_mode1", get_mode(0, 1), 32'd0);

    // Saturating ends
    tick(2'b00, 2'b00, 2'b11);
    st_b0 = 0;
    repeat (6) tick(2'b00, 2'b01, 2'b00);
    check("sat_dec_steps", 32'(st_b0), 32'd0);
    check("sat_dec_mode", get_mode(1, 0), 32'd0);
    repeat (6) tick(2'b01, 2'b00, 2'b00);
    check("sat_inc_steps", 32'(st_b0), 32'd2);
    check("sat_inc_mode", get_mode(1, 0), 32'd2);

    // Timeout of 8 idle cycles discards the first pulse
    tick(2'b00, 2'b00, 2'b11);
    tick(2'b01, 2'b00, 2'b00);
    repeat (8) tick(2'b00, 2'b00, 2'b00);
    tick(2'b01, 2'b00, 2'b00);
    check("to_expired_step", get_step(2, 0), 32'd0);
    tick(2'b01, 2'b00, 2'b00);
    check("to_after_step", get_step(2, 0), 32'd1);
    check("to_after_mode", get_mode(2, 0), 32'd1);
    tick(2'b01, 2'b00, 2'b00);
    repeat (7) tick(2'b00, 2'b00, 2'b00);
    tick(2'b01, 2'b00, 2'b00);
    check("to_within_step", get_step(2, 0), 32'd1);
    check("to_within_mode", get_mode(2, 0), 32'd2);

    // Conflicting pulses, then a direction reversal
    tick(2'b00, 2'b00, 2'b11);
    tick(2'b11, 2'b11, 2'b00);
    check("conflict_mode", get_mode(0, 0), 32'd0);
    st_a0 = 0;
    tick(2'b01, 2'b00, 2'b00);
    tick(2'b00, 2'b01, 2'b00);
    tick(2'b00, 2'b01, 2'b00);
    check("reverse_steps", 32'(st_a0), 32'd1);
    check("reverse_mode", get_mode(0, 0), 32'd2);

    // Clear beats a completing pulse; reset discards partial count
    tick(2'b00, 2'b00, 2'b11);
    tick(2'b01, 2'b00, 2'b00);
    tick(2'b01, 2'b00, 2'b01);
    check("clr_win_mode", get_mode(0, 0), 32'd0);
    check("clr_win_step", get_step(0, 0), 32'd0);
    tick(2'b01, 2'b00, 2'b00);
    do_reset();
    tick(2'b01, 2'b00, 2'b00);
    check("rst_discard_step", get_step(0, 0), 32'd0);

    // Randomised traffic with occasional idle runs, clears and a reset
    for (int n = 0; n < 600; n++) begin
      ri = 2'($urandom_range(0, 3));
      rd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) rd = rd & ~ri;
      rc[0] = ($urandom_range(0, 49) == 0);
      rc[1] = ($urandom_range(0, 49) == 0);
      tick(ri, rd, rc);
      if ($urandom_range(0, 14) == 0)
        repeat ($urandom_range(3, 10)) tick(2'b00, 2'b00, 2'b00);
      if (n == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_mode_sel.md
KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 Parameter CH, default 2: number of independent key channels, legal range 1..8.
REQ-002 Parameter MODES, default 3: number of mode values per channel, legal range 2..16.
REQ-003 Parameter PPS, default 2: qualifying pulses required per mode step, legal range 1..4.
REQ-004 Parameter TIMEOUT_CYC, default 0: inter-pulse timeout in sys_clk cycles; 0 disables the timeout, legal range 0..2^20-1.
REQ-005 Parameter WRAP, default 1: 1 = mode wraps at the ends; 0 = mode saturates at 0 and MODES-1.
REQ-006 Localparam MW = max(1, clog2(MODES)): width of each mode field.
REQ-007 sys_clk  input  1  clock; all logic on the rising edge.
REQ-008 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 inc_pulse  input  CH  per-channel one-cycle increment event, bit i drives channel i.
REQ-010 dec_pulse  input  CH  per-channel one-cycle decrement event.
REQ-011 clr  input  CH  per-channel synchronous clear, level-sensitive.
REQ-012 mode  output  CH*MW  registered mode values; channel i occupies bits [i*MW +: MW].
REQ-013 step  output  CH  registered one-cycle strobe, high in the cycle in which mode[i] first shows a changed value.

Function
REQ-014 The channels SHALL be fully independent; no input of channel i affects the state of channel j.
REQ-015 Per-channel state SHALL be: pending count (0..PPS-1), pending direction (INC/DEC), timeout timer, mode, and step.
REQ-016 Per-channel priority SHALL be: clr > simultaneous inc+dec > single pulse > timeout expiry > hold.
REQ-017 clr high: mode <= 0, pending <= 0, timer <= 0, step <= 0, regardless of pulse inputs in the same cycle.
REQ-018 inc_pulse and dec_pulse both high in the same cycle (clr low): the event SHALL be ignored; all channel state unchanged except that step <= 0.
REQ-019 Single pulse whose direction matches the pending direction, or arriving with pending = 0: pending <= pending+1 with direction latched and timer reloaded to TIMEOUT_CYC.
REQ-020 Single pulse whose direction opposes a nonzero pending count: pending restarts at 1 in the new direction; this pulse counts toward the step.
REQ-021 When a counted pulse makes the count equal PPS: pending <= 0, and mode updates on that same clock edge (latency one edge from the sampled pulse).
REQ-022 Step arithmetic, INC: mode < MODES-1 -> mode+1; mode = MODES-1 -> 0 if WRAP=1, otherwise unchanged.
REQ-023 Step arithmetic, DEC: mode > 0 -> mode-1; mode = 0 -> MODES-1 if WRAP=1, otherwise unchanged.
REQ-024 step[i] SHALL be 1 for exactly one cycle only when mode[i] actually changes; a saturated step (WRAP=0) SHALL clear pending but produce no strobe.
REQ-025 PPS = 1: every single pulse is a step; the pending count and timer SHALL remain 0.
REQ-026 Timeout (TIMEOUT_CYC > 0, pending > 0, no pulse this cycle): the timer decrements by 1 per cycle; when it reaches 0 the channel sets pending <= 0 with mode unchanged.
REQ-027 TIMEOUT_CYC = 0: the pending count SHALL never expire.
REQ-028 mode SHALL never take a value >= MODES.

Reset
REQ-029 While sys_rst_n = 0, all channels SHALL hold mode = 0, step = 0, pending = 0, direction = INC, and timer = 0, asynchronously.
REQ-030 Deassertion mid-sequence SHALL discard any partial pulse count; the first pulse after reset counts as pulse 1.

Verification
REQ-031 Defaults (CH=2, MODES=3, PPS=2, WRAP=1): 6 inc pulses on ch0 -> mode0 sequence 1,2,0; step0 strobes on pulses 2, 4, 6; mode1 stays 0.
REQ-032 WRAP=0: 6 dec pulses from mode 0 -> mode stays 0 and no step. Then 6 inc pulses -> mode 1, 2, 2 with exactly 2 steps.
REQ-033 TIMEOUT_CYC=8: inc, 8 idle cycles, inc -> no step, pending = 1. Then inc within 7 cycles -> mode+1 and step.
REQ-034 Conflict and direction handling: inc and dec high in the same cycle -> no change. Then inc, dec, dec -> exactly one DEC step (mode 0 -> 2).
REQ-035 clr asserted together with the completing pulse -> mode 0, no step. Also, sys_rst_n pulsed low after 1 inc, then 1 inc -> no step.
